// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizing for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BURST_LEN = 8;
  localparam int unsigned HOST_ADDR_W   = 32;
  localparam int unsigned BEAT_W        = 8;
  localparam int unsigned STALL_W       = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Host, write-requester, read-requester, RAM and stall-stat signals of the arbiter.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                   reg_write;
  logic                   reg_read;
  logic [HOST_ADDR_W-1:0] reg_address;
  logic [DATA_W-1:0]      reg_write_data;
  logic [DATA_W-1:0]      reg_read_data;

  logic                   wr_req;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_gnt;

  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_gnt;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;

  logic                   ram_we;
  logic                   ram_re;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;

  logic [STALL_W-1:0]     wr_stall_cnt;
  logic [STALL_W-1:0]     rd_stall_cnt;

  // Arbiter side.
  modport master (
    input  reg_write, reg_read, reg_address, reg_write_data,
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  ram_rdata,
    output reg_read_data, wr_gnt, rd_gnt, rd_data, rd_valid,
    output ram_we, ram_re, ram_addr, ram_wdata,
    output wr_stall_cnt, rd_stall_cnt
  );

  // Host / requester / RAM side.
  modport slave (
    output reg_write, reg_read, reg_address, reg_write_data,
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr,
    output ram_rdata,
    input  reg_read_data, wr_gnt, rd_gnt, rd_data, rd_valid,
    input  ram_we, ram_re, ram_addr, ram_wdata,
    input  wr_stall_cnt, rd_stall_cnt
  );

endinterface

// File: rtl/ram_arb_sat_ctr.sv
// 16-bit saturating event counter used for requester stall statistics.
module ram_arb_sat_ctr
  import ram_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [STALL_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + STALL_W'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: host has absolute priority, writer/reader share bursts round-robin.
// Define ARB_STATS_EN to build the requester stall counters.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
)(
  input  logic               okClk,
  input  logic               reset,
  ram_port_arbiter_if.master bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);

  arb_state_e        state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;
  logic              last_rd;

  logic              host_act;
  logic              host_wr;
  logic              host_rd;
  logic              pick_wr;
  logic              pick_rd;
  logic              wr_gnt;
  logic              rd_gnt;

  logic              host_rd_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              rd_valid_q;

  logic              addr_hi_unused;

  assign addr_hi_unused = ^bus.reg_address[HOST_ADDR_W-1:ADDR_W];

  // Grant decision: host pre-empts, IDLE picks round-robin, bursts only serve their owner.
  always_comb begin
    host_wr  = bus.reg_write;
    host_rd  = bus.reg_read & ~bus.reg_write;
    host_act = bus.reg_write | bus.reg_read;
    pick_wr  = bus.wr_req & (~bus.rd_req | last_rd);
    pick_rd  = bus.rd_req & (~bus.wr_req | ~last_rd);
    beat_nxt = beat_cnt + BEAT_W'(1);
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    if (!reset && !host_act) begin
      case (state)
        IDLE: begin
          wr_gnt = pick_wr;
          rd_gnt = pick_rd;
        end
        WR_BURST: wr_gnt = bus.wr_req;
        RD_BURST: rd_gnt = bus.rd_req;
        default: begin
          wr_gnt = 1'b0;
          rd_gnt = 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_gnt    = rd_gnt;
  assign bus.ram_we    = ~reset & (host_wr | wr_gnt);
  assign bus.ram_re    = ~reset & (host_rd | rd_gnt);
  assign bus.ram_addr  = host_act ? bus.reg_address[ADDR_W-1:0]
                       : (rd_gnt ? bus.rd_addr : bus.wr_addr);
  assign bus.ram_wdata = host_wr ? bus.reg_write_data : bus.wr_data;

  // Burst FSM; the first beat is granted from IDLE so bursts run back to back.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_rd  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_gnt || rd_gnt) begin
            if (beat_nxt == LAST_BEAT) begin
              last_rd <= rd_gnt;
            end else begin
              state    <= wr_gnt ? WR_BURST : RD_BURST;
              beat_cnt <= beat_nxt;
            end
          end
        end
        WR_BURST: begin
          if (!bus.wr_req || (wr_gnt && (beat_nxt == LAST_BEAT))) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_rd  <= 1'b0;
          end else if (wr_gnt) begin
            beat_cnt <= beat_nxt;
          end
        end
        RD_BURST: begin
          if (!bus.rd_req || (rd_gnt && (beat_nxt == LAST_BEAT))) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_rd  <= 1'b1;
          end else if (rd_gnt) begin
            beat_cnt <= beat_nxt;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Read-return tracking for host and reader.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      host_rd_q    <= 1'b0;
      host_rdata_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      host_rd_q  <= host_rd;
      rd_valid_q <= rd_gnt;
      if (host_rd_q) begin
        host_rdata_q <= bus.ram_rdata;
      end
    end
  end

  // Host read data appears the cycle after the read, then is held until the next one.
  assign bus.reg_read_data = host_rd_q ? bus.ram_rdata : host_rdata_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_valid_q ? bus.ram_rdata : '0;

`ifdef ARB_STATS_EN
  logic [STALL_W-1:0] wr_stall;
  logic [STALL_W-1:0] rd_stall;

  ram_arb_sat_ctr u_wr_stall (
    .clk (okClk),
    .rst (reset),
    .inc (bus.wr_req & ~wr_gnt),
    .cnt (wr_stall)
  );

  ram_arb_sat_ctr u_rd_stall (
    .clk (okClk),
    .rst (reset),
    .inc (bus.rd_req & ~rd_gnt),
    .cnt (rd_stall)
  );

  assign bus.wr_stall_cnt = wr_stall;
  assign bus.rd_stall_cnt = rd_stall;
`else
  assign bus.wr_stall_cnt = '0;
  assign bus.rd_stall_cnt = '0;
`endif

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter BURST_LEN, default 8, maximum consecutive beats per requester grant (range 1..255).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: okClk  in  1  sole clock, all logic on rising edge; reset  in  1  asynchronous, active-high.
REQ-005 SHALL have host port signals: reg_write in 1; reg_read in 1; reg_address in 32; reg_write_data in DATA_W; reg_read_data out DATA_W.
REQ-006 SHALL have write-requester signals: wr_req in 1; wr_addr in ADDR_W; wr_data in DATA_W; wr_gnt out 1.
REQ-007 SHALL have read-requester signals: rd_req in 1; rd_addr in ADDR_W; rd_gnt out 1; rd_data out DATA_W; rd_valid out 1.
REQ-008 SHALL have RAM-port signals: ram_we out 1; ram_re out 1; ram_addr out ADDR_W; ram_wdata out DATA_W; ram_rdata in DATA_W, valid one cycle after ram_re.
REQ-009 SHALL have stats signals: wr_stall_cnt out 16; rd_stall_cnt out 16.

Function
REQ-010 SHALL give the host absolute priority: in any cycle with reg_write or reg_read high, the RAM port carries the host access and wr_gnt and rd_gnt are low.
REQ-011 SHALL resolve simultaneous reg_write and reg_read as a write only.
REQ-012 SHALL use reg_address[ADDR_W-1:0] and ignore the upper bits.
REQ-013 SHALL load reg_read_data from ram_rdata one cycle after a host read and hold it until the next host read.
REQ-014 SHALL keep wr_gnt and rd_gnt combinational in the same cycle; a beat completes in a cycle where req and gnt are both high.
REQ-015 SHALL assert wr_gnt so that ram_we=1, ram_addr=wr_addr and ram_wdata=wr_data in that cycle.
REQ-016 SHALL assert rd_gnt so that ram_re=1 and ram_addr=rd_addr in that cycle, then return rd_valid=1 with rd_data=ram_rdata in the next cycle only.
REQ-017 SHALL implement the FSM with states IDLE, WR_BURST and RD_BURST.
REQ-018 SHALL, in IDLE, award the grant round-robin, preferring the requester not granted last: if only one requester is active, go to its burst state; if none is active, stay in IDLE.
REQ-019 SHALL increment the beat counter on each completed beat in a burst state.
REQ-020 SHALL return from a burst state to IDLE when the beat counter reaches BURST_LEN or the owner's req drops; the last-granted pointer updates on that exit.
REQ-021 SHALL suspend a burst during host-preempted cycles without ending it; the beat counter holds.
REQ-022 SHALL never issue a grant to the non-owner while in a burst state.
REQ-023 SHALL hold ram_we and ram_re at 0 when no access occurs; ram_addr and ram_wdata are don't-care then.
REQ-024 SHALL, when wr_req and rd_req both rise in IDLE after reset, grant the writer first.

Reset
REQ-025 SHALL, on reset assertion, drive immediately: FSM=IDLE, beat counter=0, pointer="read last" (writer favoured), reg_read_data=0, rd_data=0, rd_valid=0, stall counters=0.
REQ-026 SHALL abandon an in-flight burst on reset; an rd_valid that was due is suppressed.
REQ-027 SHALL force wr_gnt, rd_gnt, ram_we and ram_re low while reset is high.

Configuration
REQ-028 SHALL, with ARB_STATS_EN defined, count in wr_stall_cnt and rd_stall_cnt the cycles where req=1 and gnt=0, saturating at 16'hFFFF.
REQ-029 SHALL, without ARB_STATS_EN, keep the ports present and tied to 0, with no counter logic.

Structure
REQ-030 SHALL place in package ram_port_arbiter_pkg the FSM state enum, default ADDR_W/DATA_W/BURST_LEN constants and the stall-counter width.
REQ-031 SHALL implement the counter as sub-module ram_arb_sat_ctr (16-bit saturating, inc enable), instantiated twice, only under ARB_STATS_EN.

Verification
REQ-032 SHALL verify: host write 0x12345678 to addr 0x403 -> ram_we=1, ram_addr=0x003; next-cycle host read of 0x003 -> reg_read_data=0x12345678.
REQ-033 SHALL verify: wr_req and rd_req held continuously from reset, BURST_LEN=8 -> 8 wr_gnt beats, then 8 rd_gnt beats, alternating; rd_valid follows each rd_gnt by exactly 1 cycle.
REQ-034 SHALL verify: reg_read pulsed during beat 3 of a write burst -> that cycle wr_gnt=0, burst resumes and completes with 8 total beats.
REQ-035 SHALL verify: reg_write and wr_req in the same cycle to addr 0x010 with data 0xA/0xB -> RAM holds 0xA and the writer stalls one cycle.
REQ-036 SHALL verify: reset asserted mid read-burst -> outputs zero asynchronously; after release, with both reqs high, writer granted first.
REQ-037 SHALL verify, with ARB_STATS_EN: rd_req held during a full 8-beat write burst -> rd_stall_cnt=8; with the macro undefined -> 0.
